// File: rtl/sd_cmd_resp_rx_pkg.sv
// Shared SD CMD-line definitions: frame lengths, CRC7 polynomial and receiver states.
// Common to the command sender and the response receiver.
package sd_cmd_resp_rx_pkg;

  localparam int unsigned SD_SHORT_LEN = 48;
  localparam int unsigned SD_LONG_LEN  = 136;
  localparam int unsigned SD_NCR_MAX   = 64;
  localparam int unsigned SD_CRC_LO    = 8;

  // x^7 + x^3 + 1, bit 7 is the implicit leading term
  localparam logic [7:0] SD_CRC7_POLY = 8'h89;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RECV,
    ST_CHECK,
    ST_FIN
  } rx_state_t;

endpackage

// File: rtl/sd_cmd_resp_rx_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), one bit per enable; clear has priority.
module sd_crc7
  import sd_cmd_resp_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;

  always_comb begin
    fb = crc[6] ^ bit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{fb}} & SD_CRC7_POLY[6:0]);
    end
  end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// Host-side SD CMD response receiver: waits for the start bit, shifts in a 48/136-bit
// frame on SAMPLE_EN strobes, then checks CRC7, transmission bit and end bit.
module sd_cmd_resp_rx
  import sd_cmd_resp_rx_pkg::*;
#(
  parameter int unsigned NCR_MAX   = SD_NCR_MAX,
  parameter int unsigned SHORT_LEN = SD_SHORT_LEN,
  parameter int unsigned LONG_LEN  = SD_LONG_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic                start,
  input  logic                long_resp,
  input  logic                crc_check,
  input  logic                cmd_in,
  output logic                busy,
  output logic                done,
  output logic [LONG_LEN-1:0] resp,
  output logic                timeout,
  output logic                crc_err,
  output logic                frame_err
);

  localparam int unsigned WW = $clog2(NCR_MAX + 1);

  rx_state_t      state, state_nxt;
  logic           long_q, crc_chk_q;
  logic [WW-1:0]  wait_cnt;
  logic [7:0]     bit_cnt;
  logic [7:0]     last_bit, crc_hi, idx;
  logic           wait_last, crc_en, crc_clr;
  logic [6:0]     crc;

  // idx is the frame bit position (MSB = len-1) of the bit being sampled in RECV
  always_comb begin
    last_bit  = long_q ? 8'(LONG_LEN - 1) : 8'(SHORT_LEN - 1);
    crc_hi    = long_q ? 8'(LONG_LEN - 9) : 8'(SHORT_LEN - 1);
    idx       = last_bit - bit_cnt;
    wait_last = (wait_cnt == WW'(NCR_MAX - 1));
    crc_en    = (state == ST_RECV) && sample_en &&
                (idx <= crc_hi) && (idx >= 8'(SD_CRC_LO));
    crc_clr   = (state == ST_WAIT) && sample_en && !cmd_in;
  end

  sd_crc7 u_crc7 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (cmd_in),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (sample_en) begin
          if (!cmd_in)        state_nxt = ST_RECV;
          else if (wait_last) state_nxt = ST_FIN;
        end
      end
      ST_RECV:  if (sample_en && (bit_cnt == last_bit)) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_WAIT) || (state == ST_RECV) || (state == ST_CHECK);
    done = (state == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q    <= 1'b0;
      crc_chk_q <= 1'b0;
      wait_cnt  <= '0;
      bit_cnt   <= '0;
      resp      <= '0;
      timeout   <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            long_q    <= long_resp;
            crc_chk_q <= crc_check;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            resp      <= '0;
            timeout   <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (sample_en) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (!cmd_in) begin
              bit_cnt <= 8'd1;
              resp    <= {resp[LONG_LEN-2:0], 1'b0};
            end else if (wait_last) begin
              timeout <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (sample_en) begin
            resp <= {resp[LONG_LEN-2:0], cmd_in};
            if (bit_cnt != 8'hFF) bit_cnt <= bit_cnt + 8'd1;
          end
        end
        ST_CHECK: begin
          frame_err <= (long_q ? resp[LONG_LEN-2] : resp[SHORT_LEN-2]) | ~resp[0];
          crc_err   <= crc_chk_q & (crc != resp[7:1]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Self-checking bench for sd_cmd_resp_rx: directed vector table, hand-written corner
// sequences and randomized frames against a polynomial-division CRC7 model.
module tb_sd_cmd_resp_rx;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_en = 1'b0;
  logic         start = 1'b0;
  logic         long_resp = 1'b0;
  logic         crc_check = 1'b0;
  logic         cmd_in = 1'b1;
  logic         busy, done, timeout, crc_err, frame_err;
  logic [135:0] resp;

  int n_total = 0;
  int n_pass  = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  sd_cmd_resp_rx #(.NCR_MAX(64), .SHORT_LEN(48), .LONG_LEN(136)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .start     (start),
    .long_resp (long_resp),
    .crc_check (crc_check),
    .cmd_in    (cmd_in),
    .busy      (busy),
    .done      (done),
    .resp      (resp),
    .timeout   (timeout),
    .crc_err   (crc_err),
    .frame_err (frame_err)
  );

  typedef struct {
    bit           lng;
    bit           cc;
    logic [135:0] frame;
    int           idle;
    logic [135:0] eresp;
    logic [2:0]   eflags;  // {timeout, crc_err, frame_err}
  } vec_t;

  vec_t vecs[7];

  function automatic void chk(string nm, logic [135:0] act, logic [135:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endfunction

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1, over frame bits hi..8
  function automatic logic [6:0] crc7_of(logic [135:0] f, int hi);
    int unsigned rem = 0;
    for (int i = hi; i >= 8; i--) begin
      rem = (rem << 1) | int'(f[i]);
      if ((rem & 32'h80) != 0) rem = rem ^ 32'h89;
    end
    for (int i = 0; i < 7; i++) begin
      rem = rem << 1;
      if ((rem & 32'h80) != 0) rem = rem ^ 32'h89;
    end
    return rem[6:0];
  endfunction

  task automatic strobe(input bit b, input int gap);
    for (int g = 0; g < gap; g++) begin
      cmd_in = 1'($urandom);
      @(posedge clk); #1;
    end
    cmd_in = b;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    cmd_in = 1'($urandom);
  endtask

  task automatic do_start(input string nm, input bit lng, input bit cc);
    start = 1'b1; long_resp = lng; crc_check = cc;
    @(posedge clk); #1;
    start = 1'b0; long_resp = 1'($urandom); crc_check = 1'($urandom);
    @(negedge clk);
    chk({nm, " busy_after_start"}, 136'(busy), 136'(1));
  endtask

  task automatic send(input logic [135:0] f, input int len, input int idle, input int maxgap);
    int nidle = (idle >= 64) ? 64 : idle;
    for (int i = 0; i < nidle; i++) strobe(1'b1, $urandom_range(0, maxgap));
    if (idle < 64)
      for (int i = len - 1; i >= 0; i--) strobe(f[i], $urandom_range(0, maxgap));
  endtask

  task automatic finish_check(input string nm, input int exp_lat,
                              input logic [135:0] eresp, input logic [2:0] ef);
    int cnt = 0;
    bit seen = 1'b0;
    while (!seen && cnt < 10) begin
      @(negedge clk);
      cnt++;
      seen = done;
    end
    chk({nm, " done_latency"}, 136'(cnt), 136'(exp_lat));
    chk({nm, " resp"}, resp, eresp);
    chk({nm, " flags"}, 136'({timeout, crc_err, frame_err}), 136'(ef));
    chk({nm, " busy_at_done"}, 136'(busy), 136'(0));
    @(negedge clk);
    chk({nm, " done_pulse"}, 136'(done), 136'(0));
    chk({nm, " flags_hold"}, 136'({timeout, crc_err, frame_err}), 136'(ef));
  endtask

  task automatic run_frame(input string nm, input bit lng, input bit cc, input logic [135:0] f,
                           input int idle, input logic [135:0] eresp, input logic [2:0] ef,
                           input int maxgap);
    do_start(nm, lng, cc);
    send(f, lng ? 136 : 48, idle, maxgap);
    finish_check(nm, (idle >= 64) ? 1 : 2, eresp, ef);
  endtask

  initial begin
    logic [135:0] r2, f;
    logic [119:0] cid;
    logic [2:0]   ef;
    bit           lng, cc, ce, fe;
    int           len, hi, idle;

    cid = 120'h035344534431364780123456780123;
    r2 = {2'b00, 6'h3F, cid, 8'h00};
    r2[7:1] = crc7_of(r2, 127);
    r2[0] = 1'b1;

    vecs[0] = '{0, 1, 136'h08000001AA13, 5,  136'h08000001AA13, 3'b000};
    vecs[1] = '{0, 1, 136'h08000001AA11, 5,  136'h08000001AA11, 3'b010};
    vecs[2] = '{0, 0, 136'h3F00FF8000FF, 3,  136'h3F00FF8000FF, 3'b000};
    vecs[3] = '{0, 0, 136'h3F00FF8000FE, 3,  136'h3F00FF8000FE, 3'b001};
    vecs[4] = '{0, 1, 136'h08000001AA13, 64, 136'h0,            3'b100};
    vecs[5] = '{0, 1, 136'h08000001AA13, 63, 136'h08000001AA13, 3'b000};
    vecs[6] = '{1, 1, r2,                2,  r2,                3'b000};

    #1;
    chk("reset outputs", 136'({busy, done, timeout, crc_err, frame_err}), 136'(0));
    chk("reset resp", resp, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].lng, vecs[i].cc, vecs[i].frame,
                vecs[i].idle, vecs[i].eresp, vecs[i].eflags, 2);

    // START during WAIT must not relatch length or CRC mode
    do_start("busy_start", 1'b0, 1'b1);
    strobe(1'b1, 1);
    strobe(1'b1, 0);
    start = 1'b1; long_resp = 1'b1; crc_check = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    send(136'h08000001AA11, 48, 2, 1);
    finish_check("busy_start", 2, 136'h08000001AA11, 3'b010);

    // strobe coincident with START is not sampled as a start bit
    start = 1'b1; long_resp = 1'b0; crc_check = 1'b1; sample_en = 1'b1; cmd_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; sample_en = 1'b0; cmd_in = 1'b1;
    send(136'h08000001AA13, 48, 3, 1);
    finish_check("start_and_strobe", 2, 136'h08000001AA13, 3'b000);

    // reset at bit 20 of a frame abandons it without DONE
    do_start("mid_reset", 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) strobe(1'b1, 1);
    f = 136'h08000001AA13;
    for (int i = 47; i > 27; i--) strobe(f[i], 1);
    done_seen = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset outputs", 136'({busy, done, timeout, crc_err, frame_err}), 136'(0));
    chk("mid_reset resp", resp, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 27; i >= 0; i--) strobe(f[i], 1);
    repeat (10) @(negedge clk);
    chk("mid_reset no_done", 136'(done_seen), 136'(0));
    chk("mid_reset idle_busy", 136'(busy), 136'(0));

    for (int n = 0; n < 30; n++) begin
      lng = 1'($urandom_range(0, 1));
      cc  = 1'($urandom_range(0, 1));
      len = lng ? 136 : 48;
      hi  = lng ? 127 : 47;
      f = '0;
      for (int i = 0; i < len; i++) f[i] = 1'($urandom);
      f[len-1] = 1'b0;
      f[len-2] = 1'b0;
      if (lng) f[133:128] = 6'h3F;
      f[7:1] = crc7_of(f, hi);
      f[0] = 1'b1;
      if ($urandom_range(0, 2) != 0) f[$urandom_range(0, len - 2)] ^= 1'b1;
      ce = cc && (crc7_of(f, hi) != f[7:1]);
      fe = f[len-2] || !f[0];
      idle = $urandom_range(0, 70);
      ef = (idle >= 64) ? 3'b100 : {1'b0, ce, fe};
      run_frame($sformatf("rand%0d", n), lng, cc, f, idle,
                (idle >= 64) ? 136'h0 : f, ef, 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
